// File: rtl/mul_arbiter.sv
// Four-requester signed-magnitude multiplier with a two-stage pipeline.
// MUL_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority.
module mul_arbiter #(
  parameter int unsigned OVF_LIMIT = 8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [27:0] req_a_mag,
  input  logic [3:0]  req_a_sign,
  input  logic [27:0] req_b_mag,
  input  logic [3:0]  req_b_sign,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_id,
  output logic [31:0] res_out,
  output logic        res_sign,
  output logic        res_overflow,
  output logic        busy
);

  logic       stall;
  logic       xfer;
  logic [3:0] grant;
  logic [1:0] gIdx;

  logic       s1Valid;
  logic [6:0] s1AMag;
  logic [6:0] s1BMag;
  logic       s1Sign;
  logic [1:0] s1Id;

  logic        s2Valid;
  logic [13:0] s2Prod;
  logic        s2Sign;
  logic        s2Ovf;
  logic [1:0]  s2Id;

  logic [13:0] prod;

  assign stall = s2Valid & ~res_ready;
  assign req_ready = (rst | stall) ? 4'b0000 : grant;
  assign xfer = |req_ready;
  assign prod = 14'(s1AMag) * 14'(s1BMag);

`ifdef MUL_ARB_RR_EN
  logic [1:0] ptr;
  logic [1:0] idx;

  // Round-robin: first valid requester at or after the pointer.
  always_comb begin
    grant = 4'b0000;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (grant == 4'b0000 && req_valid[idx])
        grant[idx] = 1'b1;
    end
  end

  // Pointer moves past the requester just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 2'd0;
    else if (xfer)
      ptr <= gIdx + 2'd1;
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant = 4'b0000;
    priority case (1'b1)
      req_valid[0]: grant = 4'b0001;
      req_valid[1]: grant = 4'b0010;
      req_valid[2]: grant = 4'b0100;
      req_valid[3]: grant = 4'b1000;
      default:      grant = 4'b0000;
    endcase
  end
`endif

  // Encode the one-hot grant for operand selection.
  always_comb begin
    gIdx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (grant[i])
        gIdx = 2'(i);
  end

  // S1 captures the granted operands unless the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1AMag  <= '0;
      s1BMag  <= '0;
      s1Sign  <= 1'b0;
      s1Id    <= 2'd0;
    end else if (!stall) begin
      s1Valid <= xfer;
      if (xfer) begin
        s1AMag <= req_a_mag[7*gIdx +: 7];
        s1BMag <= req_b_mag[7*gIdx +: 7];
        s1Sign <= req_a_sign[gIdx] ^ req_b_sign[gIdx];
        s1Id   <= gIdx;
      end
    end
  end

  // S2 holds the finished product; zero products are positive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid <= 1'b0;
      s2Prod  <= '0;
      s2Sign  <= 1'b0;
      s2Ovf   <= 1'b0;
      s2Id    <= 2'd0;
    end else if (!stall) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Prod <= prod;
        s2Sign <= s1Sign & (prod != 14'd0);
        s2Ovf  <= 32'(prod) > OVF_LIMIT;
        s2Id   <= s1Id;
      end
    end
  end

  assign res_valid    = s2Valid;
  assign res_id       = s2Id;
  assign res_out      = {18'b0, s2Prod};
  assign res_sign     = s2Sign;
  assign res_overflow = s2Ovf;
  assign busy         = s1Valid | s2Valid;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter.
// Checks reset, arithmetic, arbitration, backpressure and mid-flight reset.
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [27:0] req_a_mag;
  logic [3:0]  req_a_sign;
  logic [27:0] req_b_mag;
  logic [3:0]  req_b_sign;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [31:0] res_out;
  logic        res_sign;
  logic        res_overflow;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_mag(req_a_mag), .req_a_sign(req_a_sign),
    .req_b_mag(req_b_mag), .req_b_sign(req_b_sign),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_out(res_out),
    .res_sign(res_sign), .res_overflow(res_overflow),
    .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input int i,
                       input logic as, input logic [6:0] am,
                       input logic bs, input logic [6:0] bm);
    req_a_mag[7*i +: 7] = am;
    req_b_mag[7*i +: 7] = bm;
    req_a_sign[i] = as;
    req_b_sign[i] = bs;
  endtask

  task automatic singleOp(input string tag, input int i,
                          input logic as, input logic [6:0] am,
                          input logic bs, input logic [6:0] bm,
                          input int eOut, input logic eSign,
                          input logic eOvf);
    setOp(i, as, am, bs, bm);
    req_valid = 4'b0001 << i;
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << i));
    step();
    req_valid = 4'b0000;
    chk({tag, "_lat1"}, 32'(res_valid), 0);
    step();
    chk({tag, "_valid"}, 32'(res_valid), 1);
    chk({tag, "_id"}, 32'(res_id), 32'(i));
    chk({tag, "_out"}, res_out, 32'(eOut));
    chk({tag, "_sign"}, 32'(res_sign), 32'(eSign));
    chk({tag, "_ovf"}, 32'(res_overflow), 32'(eOvf));
    step();
    chk({tag, "_drain"}, 32'(busy), 0);
  endtask

  initial begin
    logic [3:0] exp [8];
    rst = 1'b1;
    req_valid = 4'b1111;
    req_a_mag = '0;
    req_b_mag = '0;
    req_a_sign = '0;
    req_b_sign = '0;
    res_ready = 1'b1;
    #12;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_id", 32'(res_id), 0);
    chk("rst_out", res_out, 0);
    chk("rst_sign", 32'(res_sign), 0);
    chk("rst_ovf", 32'(res_overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    req_valid = 4'b0000;
    step();
    rst = 1'b0;

    singleOp("single", 2, 1'b0, 7'd5, 1'b1, 7'd7, 35, 1'b1, 1'b0);
    singleOp("max", 0, 1'b0, 7'd127, 1'b1, 7'd127, 16129, 1'b1, 1'b1);
    singleOp("zero", 1, 1'b1, 7'd0, 1'b1, 7'd9, 0, 1'b0, 1'b0);
    singleOp("nearlim", 3, 1'b1, 7'd91, 1'b1, 7'd90, 8190, 1'b0, 1'b0);
    singleOp("abovelim", 3, 1'b0, 7'd82, 1'b0, 7'd100, 8200, 1'b0, 1'b1);

    // Backpressure with both stages full.
    res_ready = 1'b0;
    setOp(0, 1'b0, 7'd3, 1'b0, 7'd4);
    setOp(1, 1'b1, 7'd5, 1'b0, 7'd6);
    setOp(2, 1'b0, 7'd2, 1'b0, 7'd2);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0100;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_id", 32'(res_id), 0);
      chk("bp_out", res_out, 12);
      step();
    end
    req_valid = 4'b0000;
    res_ready = 1'b1;
    step();
    chk("bp_y_valid", 32'(res_valid), 1);
    chk("bp_y_id", 32'(res_id), 1);
    chk("bp_y_out", res_out, 30);
    chk("bp_y_sign", 32'(res_sign), 1);
    step();
    chk("bp_empty", 32'(res_valid), 0);

    // Contention with every requester or with requesters 1 and 3.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) setOp(i, 1'b0, 7'(i + 1), 1'b0, 7'd1);
`ifdef MUL_ARB_RR_EN
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) exp[n] = 4'b0001 << (n % 4);
`else
    req_valid = 4'b1010;
    for (int n = 0; n < 8; n++) exp[n] = 4'b0010;
`endif
    for (int n = 0; n < 8; n++) begin
      #1;
      chk("arb_grant", 32'(req_ready), 32'(exp[n]));
      step();
      if (n >= 1) begin
        chk("arb_valid", 32'(res_valid), 1);
        chk("arb_id", 32'(res_id), 32'($clog2(int'(exp[n-1]))));
      end
    end
    req_valid = 4'b0000;
    step();
    step();

    // Reset one cycle after a transfer.
    setOp(3, 1'b0, 7'd9, 1'b0, 7'd9);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_valid", 32'(res_valid), 0);
    step();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("mid_after", 32'(res_valid), 0);
      step();
    end
    req_valid = 4'b1111;
    #1;
    chk("mid_ptr", 32'(req_ready), 32'(4'b0001));
    req_valid = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: OVF_LIMIT, default 8191, largest product magnitude reported without overflow.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  in  4  per-requester operation request; bit i belongs to requester i.
REQ-005 Port: req_ready  out  4  one-hot grant; transfer for requester i when req_valid[i] & req_ready[i].
REQ-006 Port: req_a_mag  in  28  operand A magnitudes, 7 bits per requester, requester i at bits [7i+6:7i].
REQ-007 Port: req_a_sign  in  4  operand A sign bits, 1 = negative.
REQ-008 Port: req_b_mag  in  28  operand B magnitudes, same packing as req_a_mag.
REQ-009 Port: req_b_sign  in  4  operand B sign bits.
REQ-010 Port: res_valid  out  1  result present on res_* outputs.
REQ-011 Port: res_ready  in  1  consumer accepts result when res_valid & res_ready.
REQ-012 Port: res_id  out  2  index of requester that issued the result.
REQ-013 Port: res_out  out  32  product magnitude, zero-extended to 32 bits.
REQ-014 Port: res_sign  out  1  product sign.
REQ-015 Port: res_overflow  out  1  product magnitude exceeds OVF_LIMIT.
REQ-016 Port: busy  out  1  high while any pipeline stage holds a valid operation.

Function
REQ-017 Pipeline: two stages, S1 (registered operands + id), S2 (registered product, sign, overflow, id); S2 drives res_*.
REQ-018 Latency: result appears on res_* exactly 2 cycles after the transfer cycle when no stall.
REQ-019 Stall: when res_valid & ~res_ready, S2 and S1 hold, req_ready = 0.
REQ-020 Advance: S1 accepts a new transfer in any cycle where S1 is empty or S1 moves into S2.
REQ-021 Grant: at most one req_ready bit high per cycle; req_ready is combinational from req_valid, pointer and stall state; req_ready = 0 when no requester is valid.
REQ-022 Round-robin: grant goes to the first valid requester at or after pointer, wrapping 3 -> 0; on a transfer pointer becomes (granted index + 1) mod 4.
REQ-023 Product: res_out = {18'b0, a_mag * b_mag}; 14-bit product, maximum 127*127 = 16129.
REQ-024 Sign: res_sign = a_sign ^ b_sign, forced 0 when product is zero.
REQ-025 Overflow: res_overflow = 1 iff product > OVF_LIMIT; informational only, res_out never saturated.
REQ-026 Result ordering: results leave in transfer order; no result dropped or duplicated.
REQ-027 Throughput: one transfer per cycle sustained with res_ready held high.
REQ-028 busy = S1 valid | S2 valid.

Reset
REQ-029 While rst = 1: pipeline empty, pointer = 0, req_ready = 0, res_valid = 0, res_id = 0, res_out = 0, res_sign = 0, res_overflow = 0, busy = 0.
REQ-030 Reset asserted mid-operation discards all in-flight operations; no res_valid for them after release.
REQ-031 First grant is possible in the first rising edge after rst deasserts.

Configuration
REQ-032 Macro MUL_ARB_RR_EN: defined -> round-robin per REQ-022; undefined -> fixed priority, lowest valid index always wins, pointer absent.

Verification
REQ-033 Single op: requester 2, A = +5, B = -7 -> 2 cycles later res_valid, res_id = 2, res_out = 35, res_sign = 1, res_overflow = 0.
REQ-034 Overflow/zero: A = +127, B = -127 -> res_out = 16129, res_sign = 1, res_overflow = 1; A = -0, B = -9 -> res_out = 0, res_sign = 0.
REQ-035 Contention (RR build): all 4 valid continuously, res_ready = 1 -> grants 0,1,2,3,0,... one per cycle, res_id follows the same order.
REQ-036 Backpressure: res_ready = 0 for 5 cycles with S1 and S2 full -> req_ready = 0, res_* stable; after res_ready = 1 both results emerge in order.
REQ-037 Reset mid-flight: rst pulsed 1 cycle after transfer -> res_valid never asserts for that op, pointer = 0, busy = 0.
REQ-038 Fixed-priority build: requesters 1 and 3 valid continuously -> requester 1 granted every cycle, requester 3 never.
